// File: rtl/tl_pkg.sv
// Shared types for the intersection scheduler: light encoding, phase codes, road ids.
package tl_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        ALL_RED  = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4
    } phase_t;

    typedef enum logic {
        ROAD_A = 1'b0,
        ROAD_B = 1'b1
    } road_t;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Sensor inputs and light/phase outputs of the scheduler; EMERGENCY_PREEMPT_EN adds preempt signals.
interface intersection_scheduler_if;
    logic       a_sensor_1th;
    logic       a_sensor_5th;
    logic       b_sensor_1th;
    logic       b_sensor_5th;
    logic [1:0] light_a;
    logic [1:0] light_b;
    logic [2:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
    logic       preempt_road;

    modport master (
        output a_sensor_1th, a_sensor_5th, b_sensor_1th, b_sensor_5th, preempt, preempt_road,
        input  light_a, light_b, phase
    );
    modport slave (
        input  a_sensor_1th, a_sensor_5th, b_sensor_1th, b_sensor_5th, preempt, preempt_road,
        output light_a, light_b, phase
    );
`else
    modport master (
        output a_sensor_1th, a_sensor_5th, b_sensor_1th, b_sensor_5th,
        input  light_a, light_b, phase
    );
    modport slave (
        input  a_sensor_1th, a_sensor_5th, b_sensor_1th, b_sensor_5th,
        output light_a, light_b, phase
    );
`endif
endinterface

// File: rtl/tl_phase_timer.sv
// Saturating phase counter, cleared on state entry; done flags cnt >= limit-1.
module tl_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q >= (limit_i - ONE));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road right-of-way scheduler: GREEN -> YELLOW -> ALL_RED with demand-sized greens.
// Optional macro EMERGENCY_PREEMPT_EN enables preempt/preempt_road handling.
module intersection_scheduler
    import tl_pkg::*;
#(
    parameter int ALLRED_CYC  = 2,
    parameter int YELLOW_CYC  = 3,
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_SHORT = 8,
    parameter int GREEN_LONG  = 16,
    parameter int CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    intersection_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_CYC);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] SHORT_L  = CNT_W'(GREEN_SHORT);
    localparam logic [CNT_W-1:0] LONG_L   = CNT_W'(GREEN_LONG);
    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);

    phase_t           state_q, state_d;
    road_t            next_road_q, next_road_d, grant_road;
    logic [CNT_W-1:0] target_q, target_d, eff_target, limit, cnt;
    logic             done, clr, grant_en, dem_a, dem_b;
    logic [1:0]       light_a_q, light_a_d, light_b_q, light_b_d;
    logic [2:0]       phase_q, phase_d;

    assign dem_a = bus.a_sensor_1th | bus.a_sensor_5th;
    assign dem_b = bus.b_sensor_1th | bus.b_sensor_5th;

    tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .limit_i (limit),
        .cnt_o   (cnt),
        .done_o  (done)
    );

    always_comb begin
        state_d     = state_q;
        next_road_d = next_road_q;
        target_d    = target_q;
        eff_target  = target_q;
        limit       = ALLRED_L;
        grant_en    = 1'b0;
        grant_road  = next_road_q;
        case (state_q)
            ALL_RED: begin
                if (done) begin
                    if ((next_road_q == ROAD_A) ? dem_a : dem_b) begin
                        grant_en = 1'b1;
                    end else if ((next_road_q == ROAD_A) ? dem_b : dem_a) begin
                        grant_en   = 1'b1;
                        grant_road = (next_road_q == ROAD_A) ? ROAD_B : ROAD_A;
                    end
                end
            end
            A_GREEN: begin
                // A 5th-position sensor upgrades the target in the same cycle it is seen.
                eff_target = bus.a_sensor_5th ? LONG_L : target_q;
                target_d   = eff_target;
                limit      = eff_target;
                if (dem_b && (done || (cnt >= GMIN_M1 && !dem_a))) state_d = A_YELLOW;
            end
            B_GREEN: begin
                eff_target = bus.b_sensor_5th ? LONG_L : target_q;
                target_d   = eff_target;
                limit      = eff_target;
                if (dem_a && (done || (cnt >= GMIN_M1 && !dem_b))) state_d = B_YELLOW;
            end
            A_YELLOW: begin
                limit = YELLOW_L;
                if (done) begin
                    state_d     = ALL_RED;
                    next_road_d = ROAD_B;
                end
            end
            B_YELLOW: begin
                limit = YELLOW_L;
                if (done) begin
                    state_d     = ALL_RED;
                    next_road_d = ROAD_A;
                end
            end
            default: state_d = ALL_RED;
        endcase
`ifdef EMERGENCY_PREEMPT_EN
        if (bus.preempt) begin
            case (state_q)
                ALL_RED: if (done) begin
                    grant_en   = 1'b1;
                    grant_road = road_t'(bus.preempt_road);
                end
                A_GREEN: state_d = bus.preempt_road ? A_YELLOW : A_GREEN;
                B_GREEN: state_d = bus.preempt_road ? B_GREEN : B_YELLOW;
                default: ;
            endcase
        end
`endif
        if (grant_en) begin
            if (grant_road == ROAD_A) begin
                state_d  = A_GREEN;
                target_d = bus.a_sensor_5th ? LONG_L : SHORT_L;
            end else begin
                state_d  = B_GREEN;
                target_d = bus.b_sensor_5th ? LONG_L : SHORT_L;
            end
        end
    end

    assign clr = (state_d != state_q);

    always_comb begin
        light_a_d = LIGHT_RED;
        light_b_d = LIGHT_RED;
        phase_d   = state_q;
        case (state_q)
            A_GREEN:  light_a_d = LIGHT_GREEN;
            A_YELLOW: light_a_d = LIGHT_YELLOW;
            B_GREEN:  light_b_d = LIGHT_GREEN;
            B_YELLOW: light_b_d = LIGHT_YELLOW;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ALL_RED;
            next_road_q <= ROAD_A;
            target_q    <= SHORT_L;
            light_a_q   <= LIGHT_RED;
            light_b_q   <= LIGHT_RED;
            phase_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            next_road_q <= next_road_d;
            target_q    <= target_d;
            light_a_q   <= light_a_d;
            light_b_q   <= light_b_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.light_a = light_a_q;
    assign bus.light_b = light_b_q;
    assign bus.phase   = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: vector table, corner sequences, random run against a road/mode model.
module tb_intersection_scheduler;
    import tl_pkg::*;

    localparam int ALLRED = 2;
    localparam int YEL    = 3;
    localparam int GMIN   = 4;
    localparam int GSHORT = 8;
    localparam int GLONG  = 16;
    localparam int SAT    = 31;

    localparam int M_RED    = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    intersection_scheduler_if bus();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int safety_bad = 0;
    logic [6:0] exp_q[$];

    // Model: which road holds the right-of-way, in which mode, for how long.
    int m_mode = M_RED;
    int m_road = 0;
    int m_next = 0;
    int m_age  = 0;
    bit m_long = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [6:0] model_out();
        logic [1:0] la, lb, lv;
        logic [2:0] ph;
        lv = (m_mode == M_GREEN) ? 2'b10 : 2'b01;
        la = (m_mode != M_RED && m_road == 0) ? lv : 2'b00;
        lb = (m_mode != M_RED && m_road == 1) ? lv : 2'b00;
        ph = (m_mode == M_RED) ? 3'd0 : 3'(1 + 2 * m_road + ((m_mode == M_YELLOW) ? 1 : 0));
        return {la, lb, ph};
    endfunction

    task automatic model_step(input bit r, input bit a1, input bit a5, input bit b1, input bit b5);
        bit dem[2];
        bit five[2];
        int nmode, nroad, lim;
        if (!r) begin
            m_mode = M_RED; m_age = 0; m_next = 0; m_long = 1'b0;
            return;
        end
        dem[0] = a1 | a5; dem[1] = b1 | b5;
        five[0] = a5;     five[1] = b5;
        nmode = m_mode; nroad = m_road;
        case (m_mode)
            M_RED: if (m_age >= ALLRED - 1) begin
                if (dem[m_next]) begin
                    nmode = M_GREEN; nroad = m_next;
                end else if (dem[1 - m_next]) begin
                    nmode = M_GREEN; nroad = 1 - m_next;
                end
                if (nmode == M_GREEN) m_long = five[nroad];
            end
            M_GREEN: begin
                m_long = m_long | five[m_road];
                lim = m_long ? GLONG : GSHORT;
                if (dem[1 - m_road] && (m_age >= lim - 1 || (m_age >= GMIN - 1 && !dem[m_road])))
                    nmode = M_YELLOW;
            end
            default: if (m_age >= YEL - 1) begin
                nmode = M_RED; m_next = 1 - m_road;
            end
        endcase
        if (nmode != m_mode) m_age = 0;
        else if (m_age < SAT) m_age++;
        m_mode = nmode; m_road = nroad;
    endtask

    task automatic tick();
        logic [6:0] e;
        exp_q.push_back(rst ? model_out() : 7'd0);
        model_step(rst, bus.a_sensor_1th, bus.a_sensor_5th, bus.b_sensor_1th, bus.b_sensor_5th);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (bus.light_a != LIGHT_RED && bus.light_b != LIGHT_RED) safety_bad++;
        check("model", int'({bus.light_a, bus.light_b, bus.phase}), int'(e));
    endtask

    task automatic set_sensors(input bit a1, input bit a5, input bit b1, input bit b5);
        bus.a_sensor_1th = a1; bus.a_sensor_5th = a5;
        bus.b_sensor_1th = b1; bus.b_sensor_5th = b5;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        set_sensors(0, 0, 0, 0);
        tick();
        tick();
    endtask

    // Length of the next road-A green; act_kind 1 raises a5, 2 drops A demand after act_at greens.
    task automatic run_green_a(input int act_at, input int act_kind, output int len);
        int w;
        w = 0;
        len = 0;
        while (bus.light_a != LIGHT_GREEN && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) begin
            check("green_a_start_timeout", 0, 1);
            return;
        end
        len = 1;
        while (len < 60) begin
            if (len == act_at && act_kind == 1) bus.a_sensor_5th = 1'b1;
            if (len == act_at && act_kind == 2) begin
                bus.a_sensor_1th = 1'b0; bus.a_sensor_5th = 1'b0;
            end
            tick();
            if (bus.light_a != LIGHT_GREEN) break;
            len++;
        end
    endtask

    typedef struct {
        bit         r;
        bit         a1, a5, b1, b5;
        logic [1:0] la, lb;
        logic [2:0] ph;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int len, w, idle_bad;
        bit a1, a5, b1, b5;
`ifdef EMERGENCY_PREEMPT_EN
        bus.preempt = 1'b0;
        bus.preempt_road = 1'b0;
`endif
        set_sensors(0, 0, 0, 0);

        // Reset, A alone (rests green), then B arrives: 8 green, 3 yellow, 2 all-red, B green.
        tbl[0]  = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0};
        tbl[1]  = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0};
        tbl[2]  = '{1, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0};
        tbl[3]  = '{1, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0};
        tbl[4]  = '{1, 1, 0, 0, 0, 2'b10, 2'b00, 3'd1};
        tbl[5]  = '{1, 1, 0, 0, 0, 2'b10, 2'b00, 3'd1};
        tbl[6]  = '{1, 1, 0, 0, 0, 2'b10, 2'b00, 3'd1};
        for (int i = 7; i <= 11; i++) tbl[i] = '{1, 1, 0, 1, 0, 2'b10, 2'b00, 3'd1};
        for (int i = 12; i <= 14; i++) tbl[i] = '{1, 1, 0, 1, 0, 2'b01, 2'b00, 3'd2};
        tbl[15] = '{1, 1, 0, 1, 0, 2'b00, 2'b00, 3'd0};
        tbl[16] = '{1, 1, 0, 1, 0, 2'b00, 2'b00, 3'd0};
        tbl[17] = '{1, 1, 0, 1, 0, 2'b00, 2'b10, 3'd3};
        tbl[18] = '{1, 1, 0, 1, 0, 2'b00, 2'b10, 3'd3};
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].r;
            set_sensors(tbl[i].a1, tbl[i].a5, tbl[i].b1, tbl[i].b5);
            tick();
            check($sformatf("vec%0d", i), int'({bus.light_a, bus.light_b, bus.phase}),
                  int'({tbl[i].la, tbl[i].lb, tbl[i].ph}));
        end

        // Reset hold, then idle with no demand.
        reset_dut();
        check("reset_hold", int'({bus.light_a, bus.light_b, bus.phase}), 0);
        rst = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.phase != 3'd0) idle_bad++;
        end
        check("idle_50", idle_bad, 0);

        // Long green from entry.
        reset_dut();
        set_sensors(1, 1, 1, 0);
        rst = 1'b1;
        run_green_a(0, 0, len);
        check("long_green_len", len, GLONG);

        // Upgrade during green.
        reset_dut();
        set_sensors(1, 0, 1, 0);
        rst = 1'b1;
        run_green_a(4, 1, len);
        check("upgrade_green_len", len, GLONG);

        // Gap-out after A demand vanishes.
        reset_dut();
        set_sensors(1, 0, 1, 0);
        rst = 1'b1;
        run_green_a(1, 2, len);
        check("gapout_green_len", len, GMIN);

        // Reset in B green, then both demand: A first.
        reset_dut();
        set_sensors(0, 0, 1, 0);
        rst = 1'b1;
        w = 0;
        while (bus.light_b != LIGHT_GREEN && w < 20) begin
            tick();
            w++;
        end
        check("b_green_reached", int'(bus.light_b), int'(LIGHT_GREEN));
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_outputs", int'({bus.light_a, bus.light_b, bus.phase}), 0);
        set_sensors(1, 0, 1, 0);
        rst = 1'b1;
        w = 0;
        while (bus.light_a == LIGHT_RED && bus.light_b == LIGHT_RED && w < 20) begin
            tick();
            w++;
        end
        check("midrst_a_first_la", int'(bus.light_a), int'(LIGHT_GREEN));
        check("midrst_a_first_lb", int'(bus.light_b), int'(LIGHT_RED));

        // Random sensor traffic with occasional resets.
        a1 = 0; a5 = 0; b1 = 0; b5 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) a1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) a5 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) b1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) b5 = 1'($urandom_range(0, 1));
            set_sensors(a1, a5, b1, b5);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end

        check("safety_never_both", safety_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Two-road intersection controller sharing one right-of-way between road A and road B.
- Each approach has the standard queue sensors (sensor_1th = at least one car waiting, sensor_5th = queue reaches the 5th position).
- Sequences GREEN → YELLOW → ALL_RED per road, sizes green time from queue depth, and skips or rests on roads according to demand.
- Sits above the per-approach light drivers and uses the same 2-bit light encoding.

Parameters:
- ALLRED_CYC, 2, cycles both roads are RED between phases
- YELLOW_CYC, 3, cycles of YELLOW
- GREEN_MIN, 4, minimum green cycles before a gap-out is allowed
- GREEN_SHORT, 8, green target when only sensor_1th is set
- GREEN_LONG, 16, green target when sensor_5th is set
- CNT_W, 5, phase counter width; must hold GREEN_LONG

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- a_sensor_1th  in  1  road A car waiting
- a_sensor_5th  in  1  road A queue ≥5
- b_sensor_1th  in  1  road B car waiting
- b_sensor_5th  in  1  road B queue ≥5
- light_a  out  2  road A light: 00 RED, 01 YELLOW, 10 GREEN
- light_b  out  2  road B light, same encoding
- phase  out  3  current state code, for debug/verification

Behaviour:
- Demand: dem_x = x_sensor_1th | x_sensor_5th. Sensors are sampled on the rising edge of clk. All outputs are registered and decoded from the state register.
- States, with phase codes: ALL_RED=0, A_GREEN=1, A_YELLOW=2, B_GREEN=3, B_YELLOW=4. Codes 5–7 are illegal and recover to ALL_RED.
- Counter behaviour:
  - cnt clears to 0 on every state entry and increments each cycle, saturating at 2^CNT_W-1.
  - A state "lasts N cycles" means it exits on the edge where cnt==N-1.
- Reset (rst==0 at a clock edge):
  - state=ALL_RED, cnt=0, next_road=A, target=GREEN_SHORT.
  - light_a=light_b=00, phase=0.
  - Reset mid-operation takes effect on that edge from any state; there is no yellow clearance.
- ALL_RED:
  - Both lights are 00 for at least ALLRED_CYC cycles.
  - Once ALLRED_CYC is met, grant next_road if it has demand. Otherwise grant the other road if it has demand. Otherwise stay in ALL_RED (idle) and re-evaluate every cycle.
  - If both roads demand, next_road wins.
- x_GREEN:
  - On entry, latch target=GREEN_LONG if x_sensor_5th is set, else GREEN_SHORT.
  - During green, x_sensor_5th=1 upgrades target to GREEN_LONG. target never downgrades.
  - Exit to x_YELLOW when either of these holds:
    - (a) cnt ≥ target-1 and the other road has demand, or
    - (b) gap-out: cnt ≥ GREEN_MIN-1, !dem_x, and the other road has demand.
  - If the other road has no demand, rest in green indefinitely (cnt saturates). Exit the cycle after the other road's demand appears, provided (a) or (b) holds.
- x_YELLOW: lasts YELLOW_CYC cycles, then go to ALL_RED with next_road = the other road.
- Safety: light_a and light_b are never both non-00 in the same cycle.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- Defined:
  - Adds ports preempt (in, 1) and preempt_road (in, 1; 0 = A, 1 = B).
  - When preempt=1 and the requested road is currently RED: any green on the other road goes to its YELLOW immediately, ignoring GREEN_MIN. That yellow still lasts YELLOW_CYC, then ALL_RED lasts ALLRED_CYC, then the requested road goes GREEN.
  - The requested road's green holds for as long as preempt=1, then normal rules resume.
  - If preempt is asserted while the requested road is already GREEN, that road holds green.
- Undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package tl_pkg holds:
  - light encoding constants LIGHT_RED/YELLOW/GREEN;
  - phase_t enum with the codes above;
  - road_t (A=0, B=1).
- Sub-module tl_phase_timer: the saturating cnt with clear-on-entry and a comparison output done = (cnt ≥ limit-1). It is instantiated once, and the limit is muxed per state.

Test Plan:
- Reset hold: rst=0 for 2 cycles with all sensors 0 → light_a=light_b=00, phase=0. After release, phase stays 0 for 50 cycles.
- Single demand: release rst, a_sensor_1th=1 → light_a=10 on the 3rd edge after release (2 ALL_RED cycles), then rests in green while B is idle.
- Normal alternation: A resting green, b_sensor_1th=1, a_sensor_1th held 1 → light_a=10 for 8 cycles total from green entry, 01 for 3, 00/00 for 2, then light_b=10.
- Long green: a_sensor_5th=1 at A green entry and B demanding → A green lasts exactly 16 cycles.
- Upgrade: a_sensor_5th rises at cycle 5 of A green with B demanding → A green lasts 16 cycles.
- Gap-out: A green, a sensors drop to 0 at cycle 1, B demanding → A green lasts exactly 4 cycles.
- Mid-operation reset: rst=0 during B_GREEN → on that edge lights=00/00, phase=0. Afterwards A is granted first if both roads demand. The checker asserts no cycle ever has both lights non-00.
